// File: rtl/mk_hsk_pkg.sv
// Shared types for the 4-phase source-side handshake controller:
// FSM state encoding and watchdog counter width.
package mk_hsk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } hsk_state_e;

   localparam int unsigned WDOG_CNT_W = 16;

endpackage

// File: rtl/mk_sync_l2l.sv
// Level-to-level multi-flop synchronizer with synchronous active-low reset.
// The output is the last flop of a SYNC_STAGE-deep shift chain.
module mk_sync_l2l #(
   parameter int   SYNC_STAGE  = 2,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGE-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_q <= {SYNC_STAGE{RESET_VALUE}};
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < SYNC_STAGE; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[SYNC_STAGE-1];

endmodule

// File: rtl/mk_hsk_src_ctrl.sv
// Source side of a 4-phase req/ack clock-domain-crossing handshake.
// Optional per-phase watchdog enabled by defining MK_HSK_SRC_TIMEOUT_EN.
module mk_hsk_src_ctrl
   import mk_hsk_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int SYNC_STAGE     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_ready,
   output logic                  xfer_req,
   output logic [DATA_WIDTH-1:0] xfer_data,
   input  logic                  xfer_ack,
   output logic                  busy,
   output logic                  timeout_err,
   input  logic                  err_clr
);

   logic                  ack_s;
   logic                  reset_n;
   logic                  accept;
   hsk_state_e            state_q, state_d;
   logic                  xfer_req_q, xfer_req_d;
   logic [DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;

   assign reset_n = ~reset;

   mk_sync_l2l #(
      .SYNC_STAGE  (SYNC_STAGE),
      .RESET_VALUE (1'b0)
   ) u_ack_sync (
      .clk    (clk),
      .resetn (reset_n),
      .d_i    (xfer_ack),
      .q_o    (ack_s)
   );

   // A stale ack still visible in IDLE must drain before a new bundle is taken.
   assign src_ready = (state_q == IDLE) && !ack_s && !reset;
   assign accept    = src_valid && src_ready;

   always_comb begin
      state_d     = state_q;
      xfer_data_d = xfer_data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = REQ;
               xfer_data_d = src_data;
            end
         end
         REQ: begin
            if (ack_s) state_d = ACK;
         end
         ACK: begin
            if (!ack_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Registered request: decoded from the next state so it toggles with the FSM.
      xfer_req_d = (state_d == REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         xfer_req_q  <= 1'b0;
         xfer_data_q <= '0;
      end else begin
         state_q     <= state_d;
         xfer_req_q  <= xfer_req_d;
         xfer_data_q <= xfer_data_d;
      end
   end

   assign xfer_req  = xfer_req_q;
   assign xfer_data = xfer_data_q;
   assign busy      = (state_q != IDLE);

`ifdef MK_HSK_SRC_TIMEOUT_EN
   localparam logic [WDOG_CNT_W-1:0] WDOG_MAX = WDOG_CNT_W'(TIMEOUT_CYCLES);
   localparam logic [WDOG_CNT_W-1:0] WDOG_PRE = WDOG_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WDOG_CNT_W-1:0] WDOG_ONE = WDOG_CNT_W'(1);

   logic [WDOG_CNT_W-1:0] wdog_q, wdog_d;
   logic                  err_q, err_d;
   logic                  phase_hold;

   assign phase_hold = (state_d == state_q) && (state_q != IDLE);

   always_comb begin
      wdog_d = wdog_q;
      if (state_d != state_q) begin
         wdog_d = '0;
      end else if (phase_hold && (wdog_q != WDOG_MAX)) begin
         wdog_d = wdog_q + WDOG_ONE;
      end
      // Set fires only on the step into WDOG_MAX, so a clear sticks while saturated.
      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (phase_hold && (wdog_q == WDOG_PRE)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign timeout_err = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign timeout_err    = 1'b0;
`endif

endmodule
